// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared FSM state type and saturation limits for the writeback path
package tpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND0 = 2'd1,
    ST_SEND1 = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

  localparam int OUT_W_DEF = 16;

  // Signed limits of a w-bit result, expressed in the 32-bit accumulator domain.
  function automatic logic signed [31:0] sat_max(input int w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  function automatic logic signed [31:0] sat_min(input int w);
    return -(32'sd1 <<< (w - 1));
  endfunction

  localparam logic signed [31:0] SAT_MAX_DEF = sat_max(OUT_W_DEF);
  localparam logic signed [31:0] SAT_MIN_DEF = sat_min(OUT_W_DEF);

endpackage

// File: rtl/post_proc.sv
// rtl/post_proc.sv - combinational ReLU, arithmetic shift and saturation, 32 bits to OUT_W
module post_proc
  import tpu_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [31:0]      din,
  input  logic             relu_en,
  input  logic [4:0]       shift,
  output logic [OUT_W-1:0] dout
);

  localparam logic signed [31:0] HI = sat_max(OUT_W);
  localparam logic signed [31:0] LO = sat_min(OUT_W);

  logic signed [31:0] relu_v;
  logic signed [31:0] shr_v;

  always_comb begin
    relu_v = (relu_en && din[31]) ? 32'sd0 : $signed(din);
    shr_v  = relu_v >>> shift;
    if (shr_v > HI) begin
      dout = HI[OUT_W-1:0];
    end else if (shr_v < LO) begin
      dout = LO[OUT_W-1:0];
    end else begin
      dout = shr_v[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/acc_writeback.sv
// rtl/acc_writeback.sv - writes two post-processed accumulator results to the unified buffer
module acc_writeback
  import tpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              full,
  input  logic [31:0]       acc_mem_0,
  input  logic [31:0]       acc_mem_1,
  input  logic              relu_en,
  input  logic [4:0]        shift,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [OUT_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        missed
);

  wb_state_e state_q, state_d;

  logic              full_q, armed_q;
  logic [31:0]       acc1_q;
  logic              relu_q;
  logic [4:0]        shift_q;
  logic [ADDR_W-1:0] base_q;

  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [OUT_W-1:0]  wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic [7:0]        missed_q, missed_d;

  logic              trig, hs;
  logic [31:0]       pp_din;
  logic              pp_relu;
  logic [4:0]        pp_shift;
  logic [OUT_W-1:0]  pp_dout;

  // armed_q blocks a trigger until full has been seen low after reset.
  assign trig = full && !full_q && armed_q;
  assign hs   = wr_valid_q && wr_ready;

  // One post_proc is shared: raw inputs for word 0 at trigger, latched word 1 afterwards.
  assign pp_din   = (state_q == ST_IDLE) ? acc_mem_0 : acc1_q;
  assign pp_relu  = (state_q == ST_IDLE) ? relu_en   : relu_q;
  assign pp_shift = (state_q == ST_IDLE) ? shift     : shift_q;

  post_proc #(.OUT_W(OUT_W)) u_post_proc (
    .din     (pp_din),
    .relu_en (pp_relu),
    .shift   (pp_shift),
    .dout    (pp_dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (trig) state_d = ST_SEND0;
      ST_SEND0: if (hs)   state_d = ST_SEND1;
      ST_SEND1: if (hs)   state_d = ST_DONE;
      ST_DONE:            state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    missed_d   = missed_q;
    if (trig && state_q != ST_IDLE && missed_q != 8'hFF) begin
      missed_d = missed_q + 8'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = base_addr;
          wr_data_d  = pp_dout;
        end
      end
      ST_SEND0: begin
        if (hs) begin
          wr_addr_d = base_q + ADDR_W'(1);
          wr_data_d = pp_dout;
        end
      end
      ST_SEND1: begin
        if (hs) begin
          wr_valid_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q     <= 1'b0;
      armed_q    <= 1'b0;
      acc1_q     <= '0;
      relu_q     <= 1'b0;
      shift_q    <= '0;
      base_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      missed_q   <= '0;
    end else begin
      full_q     <= full;
      armed_q    <= armed_q || !full;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      missed_q   <= missed_d;
      if (state_q == ST_IDLE && trig) begin
        acc1_q  <= acc_mem_1;
        relu_q  <= relu_en;
        shift_q <= shift;
        base_q  <= base_addr;
      end
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
  assign missed   = missed_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: doc/acc_writeback.md
ACC_WRITEBACK -- requirements
Module: acc_writeback

Interface
REQ-001 Parameter ADDR_W, default 8, unified-buffer write address width.
REQ-002 Parameter OUT_W, default 16, written data width (signed).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 full  input  1  accumulator full flag (level, sticky until accumulator reset).
REQ-006 acc_mem_0  input  32  accumulated result 0, two's complement.
REQ-007 acc_mem_1  input  32  accumulated result 1, two's complement.
REQ-008 relu_en  input  1  1 = clamp negative results to 0 before scaling.
REQ-009 shift  input  5  arithmetic right-shift amount applied after ReLU.
REQ-010 base_addr  input  ADDR_W  destination address of result 0.
REQ-011 wr_valid  output  1  write request to unified buffer.
REQ-012 wr_ready  input  1  unified buffer accepts write when high with wr_valid.
REQ-013 wr_addr  output  ADDR_W  write address.
REQ-014 wr_data  output  OUT_W  post-processed result.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse after second write accepted.
REQ-017 missed  output  8  saturating count of triggers dropped while busy.

Function
REQ-018 Trigger = full high this cycle and low in previous cycle (registered full_q).
REQ-019 FSM states IDLE, SEND0, SEND1, DONE; encoding free.
REQ-020 IDLE: on trigger, latch acc_mem_0/1, relu_en, shift, base_addr into internal regs; next state SEND0.
REQ-021 Inputs are never re-sampled after latch; later input changes do not affect in-flight writes.
REQ-022 Processing per word: if relu_en and value negative -> 0; then arithmetic >> shift; then saturate to signed OUT_W range.
REQ-023 Saturation: values > 2^(OUT_W-1)-1 -> 0x7FFF, < -2^(OUT_W-1) -> 0x8000 (OUT_W=16).
REQ-024 SEND0: wr_valid=1, wr_addr=base, wr_data=processed word 0; on wr_valid&&wr_ready -> SEND1.
REQ-025 SEND1: wr_valid=1, wr_addr=base+1 modulo 2^ADDR_W (0xFF wraps to 0x00), data word 1; on handshake -> DONE.
REQ-026 wr_addr/wr_data stable while wr_valid high and wr_ready low; wr_valid never drops without handshake.
REQ-027 DONE: done=1 for exactly one cycle, wr_valid=0; next state IDLE.
REQ-028 First write presented cycle after trigger (wr_valid high 1 cycle after trigger edge); minimum trigger-to-done 4 cycles with wr_ready held high.
REQ-029 Trigger while not IDLE (including DONE cycle): dropped, missed incremented, saturating at 255.
REQ-030 wr_ready while wr_valid low is ignored.
REQ-031 Outputs are registered; no combinational path from wr_ready to wr_valid/wr_addr/wr_data.

Reset
REQ-032 reset forces IDLE; wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, missed=0, full_q=0, latched regs=0.
REQ-033 reset mid-transfer abandons pending writes with no done pulse; full high at reset release counts as trigger next cycle only after full_q samples low first (i.e. no trigger unless full goes 0->1).
REQ-034 reset takes priority over every other condition in the same cycle.

Structure
REQ-035 Shared package tpu_pkg holds the FSM state enum and the OUT_W saturation limits constants.
REQ-036 One sub-module post_proc (combinational ReLU, shift, saturate, 32 -> OUT_W), instantiated twice or time-shared; FSM, latch and handshake in acc_writeback.

Verification
REQ-037 acc_mem_0=5, acc_mem_1=7, relu_en=0, shift=0, base=0x10, full 0->1, wr_ready=1 -> writes (0x10,5),(0x11,7), done 4 cycles after edge.
REQ-038 acc_mem_0=-3, acc_mem_1=-3, relu_en=1 vs 0 -> data 0,0 vs 0xFFFD,0xFFFD.
REQ-039 acc_mem_0=0x0001_0000 shift=0 -> 0x7FFF; acc_mem_1=0x0001_0000 shift=4 -> 0x1000; -70000 shift=0 -> 0x8000.
REQ-040 base=0xFF, wr_ready low 3 cycles in SEND0 -> wr_valid/addr/data held; writes to 0xFF then 0x00.
REQ-041 full toggled 0->1->0->1 during SEND1 -> missed=1, only one transfer; reset asserted in SEND0 -> wr_valid=0 next cycle, no done.
